// File: rtl/audio_sched_pkg.sv
// Shared types for the audio clip scheduler: clip source encoding (matches
// the rom_sel port) and the sample-sequencing FSM states.
package audio_sched_pkg;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_ALARM = 2'd1,
    SRC_VOICE = 2'd2,
    SRC_BEEP  = 2'd3
  } src_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    PLAY    = 2'd3
  } state_t;

  // Width of the ROM latency wait counter (latency is 1..3 cycles).
  localparam int LAT_W = 2;

  // Voice and beep play once; the alarm loops.
  function automatic logic is_one_shot(input src_t s);
    return (s == SRC_VOICE) || (s == SRC_BEEP);
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider: counts 0..CLK_DIV-1 and asserts tick
// for the single cycle in which the count sits at CLK_DIV-1.
module sample_tick_gen #(
  parameter int CLK_DIV = 12500
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count_reg;

  // Wrapping divider counter, never gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (count_reg == CNT_LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == CNT_LAST);

endmodule

// File: rtl/audio_clip_scheduler.sv
// Shares one 8-bit PWM sample path between the alarm (looping), voice and
// beep (one-shot) ROM clips. At each sample tick it arbitrates, drives the
// shared ROM address/select, waits out the ROM latency and captures the data.
module audio_clip_scheduler
  import audio_sched_pkg::*;
#(
  parameter int          CLK_DIV     = 12500,
  parameter int          ADDR_W      = 16,
  parameter int          ALARM_DEPTH = 53292,
  parameter int          VOICE_DEPTH = 48002,
  parameter int          BEEP_DEPTH  = 5439,
  parameter int          ROM_LAT     = 1,
  parameter logic [7:0]  SILENCE     = 8'h00
) (
  input  logic              clk,
  input  logic              system_reset,
  input  logic              alarm_en,
  input  logic              voice_req,
  input  logic              beep_req,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [1:0]        rom_sel,
  input  logic [7:0]        alarm_data,
  input  logic [7:0]        voice_data,
  input  logic [7:0]        beep_data,
  output logic [7:0]        sample,
  output logic              sample_valid,
  output logic              clip_done,
  output logic              busy
);

  // Elaboration-time parameter sanity: clips must fit the address space and
  // FETCH/CAPTURE must always complete inside one tick period.
  generate
    if ((ALARM_DEPTH > (1 << ADDR_W)) || (VOICE_DEPTH > (1 << ADDR_W)) ||
        (BEEP_DEPTH > (1 << ADDR_W)) || (ALARM_DEPTH < 1) ||
        (VOICE_DEPTH < 1) || (BEEP_DEPTH < 1)) begin : g_bad_depth
      $error("audio_clip_scheduler: clip depth does not fit ADDR_W");
    end
    if ((ROM_LAT < 1) || (ROM_LAT > 3) || (CLK_DIV < ROM_LAT + 3)) begin : g_bad_timing
      $error("audio_clip_scheduler: ROM_LAT must be 1..3 and CLK_DIV >= ROM_LAT+3");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] ALARM_LAST = ADDR_W'(ALARM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] VOICE_LAST = ADDR_W'(VOICE_DEPTH - 1);
  localparam logic [ADDR_W-1:0] BEEP_LAST  = ADDR_W'(BEEP_DEPTH - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(ROM_LAT - 1);

  logic tick;

  state_t             state_reg, state_next;
  src_t               play_src_reg, play_src_next;  // clip still in progress
  src_t               sel_reg, sel_next;            // source last granted
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [LAT_W-1:0]   lat_reg, lat_next;
  logic [7:0]         sample_reg, sample_next;
  logic               valid_reg, valid_next;
  logic               done_reg, done_next;
  logic               voice_pend_reg, voice_pend_next;
  logic               beep_pend_reg, beep_pend_next;

  src_t               winner;
  logic               arb;
  logic               grant;
  logic               clip_last;

  sample_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (system_reset),
    .tick  (tick)
  );

  // Priority pick: alarm preempts anything; an unfinished one-shot keeps the
  // path; otherwise voice pending beats beep pending.
  always_comb begin
    winner = SRC_NONE;
    if (alarm_en) begin
      winner = SRC_ALARM;
    end else if (is_one_shot(play_src_reg)) begin
      winner = play_src_reg;
    end else if (voice_pend_reg) begin
      winner = SRC_VOICE;
    end else if (beep_pend_reg) begin
      winner = SRC_BEEP;
    end
  end

  assign arb   = tick && ((state_reg == IDLE) || (state_reg == PLAY));
  assign grant = arb && (winner != SRC_NONE);

  // Flags the final address of the one-shot clip being captured.
  always_comb begin
    clip_last = 1'b0;
    case (sel_reg)
      SRC_VOICE: clip_last = (addr_reg == VOICE_LAST);
      SRC_BEEP:  clip_last = (addr_reg == BEEP_LAST);
      default:   clip_last = 1'b0;
    endcase
  end

  // Request capture: a pulse for a source already pending or playing is dropped.
  always_comb begin
    voice_pend_next = voice_pend_reg;
    beep_pend_next  = beep_pend_reg;
    if (grant && (winner == SRC_VOICE)) begin
      voice_pend_next = 1'b0;
    end else if (voice_req && (play_src_reg != SRC_VOICE)) begin
      voice_pend_next = 1'b1;
    end
    if (grant && (winner == SRC_BEEP)) begin
      beep_pend_next = 1'b0;
    end else if (beep_req && (play_src_reg != SRC_BEEP)) begin
      beep_pend_next = 1'b1;
    end
  end

  // FSM next-state plus address/select/sample sequencing.
  always_comb begin
    state_next    = state_reg;
    play_src_next = play_src_reg;
    sel_next      = sel_reg;
    addr_next     = addr_reg;
    lat_next      = lat_reg;
    sample_next   = sample_reg;
    valid_next    = 1'b0;
    done_next     = 1'b0;
    case (state_reg)
      IDLE, PLAY: begin
        if (grant) begin
          state_next    = FETCH;
          play_src_next = winner;
          sel_next      = winner;
          lat_next      = '0;
          if (winner == play_src_reg) begin
            // Continuing clip: the alarm wraps, one-shots never reach past last.
            if ((winner == SRC_ALARM) && (addr_reg == ALARM_LAST)) begin
              addr_next = '0;
            end else begin
              addr_next = addr_reg + 1'b1;
            end
          end else begin
            addr_next = '0;
          end
        end else if (arb && (state_reg == PLAY)) begin
          state_next    = IDLE;
          play_src_next = SRC_NONE;
          sample_next   = SILENCE;
          valid_next    = 1'b1;
        end
      end
      FETCH: begin
        if (lat_reg == LAT_LAST) begin
          state_next = CAPTURE;
        end else begin
          lat_next = lat_reg + 1'b1;
        end
      end
      CAPTURE: begin
        state_next = PLAY;
        valid_next = 1'b1;
        case (sel_reg)
          SRC_ALARM: sample_next = alarm_data;
          SRC_VOICE: sample_next = voice_data;
          SRC_BEEP:  sample_next = beep_data;
          default:   sample_next = SILENCE;
        endcase
        if (clip_last) begin
          done_next     = 1'b1;
          play_src_next = SRC_NONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath, pending flags and registered outputs.
  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      play_src_reg   <= SRC_NONE;
      sel_reg        <= SRC_NONE;
      addr_reg       <= '0;
      lat_reg        <= '0;
      sample_reg     <= SILENCE;
      valid_reg      <= 1'b0;
      done_reg       <= 1'b0;
      voice_pend_reg <= 1'b0;
      beep_pend_reg  <= 1'b0;
    end else begin
      play_src_reg   <= play_src_next;
      sel_reg        <= sel_next;
      addr_reg       <= addr_next;
      lat_reg        <= lat_next;
      sample_reg     <= sample_next;
      valid_reg      <= valid_next;
      done_reg       <= done_next;
      voice_pend_reg <= voice_pend_next;
      beep_pend_reg  <= beep_pend_next;
    end
  end

  assign rom_addr     = addr_reg;
  assign rom_sel      = sel_reg;
  assign sample       = sample_reg;
  assign sample_valid = valid_reg;
  assign clip_done    = done_reg;
  assign busy         = (state_reg != IDLE) || voice_pend_reg || beep_pend_reg;

endmodule

// File: tb/tb_audio_clip_scheduler.sv
// Directed bench for audio_clip_scheduler with small clips (alarm 4, voice 3,
// beep 2 samples), CLK_DIV=8 and ROM models returning {src, addr[5:0]}.
module tb_audio_clip_scheduler;

  logic        clk = 1'b0;
  logic        system_reset;
  logic        alarm_en;
  logic        voice_req;
  logic        beep_req;
  logic [15:0] rom_addr;
  logic [1:0]  rom_sel;
  logic [7:0]  alarm_data;
  logic [7:0]  voice_data;
  logic [7:0]  beep_data;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        clip_done;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Expected tick phase: cycle index since reset release, modulo 8.
  logic [2:0] ph;

  always #5 clk = ~clk;

  audio_clip_scheduler #(
    .CLK_DIV     (8),
    .ADDR_W      (16),
    .ALARM_DEPTH (4),
    .VOICE_DEPTH (3),
    .BEEP_DEPTH  (2),
    .ROM_LAT     (1),
    .SILENCE     (8'h00)
  ) dut (
    .clk          (clk),
    .system_reset (system_reset),
    .alarm_en     (alarm_en),
    .voice_req    (voice_req),
    .beep_req     (beep_req),
    .rom_addr     (rom_addr),
    .rom_sel      (rom_sel),
    .alarm_data   (alarm_data),
    .voice_data   (voice_data),
    .beep_data    (beep_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .clip_done    (clip_done),
    .busy         (busy)
  );

  // One-cycle-latency ROM models.
  always @(posedge clk) begin
    alarm_data <= {2'd1, rom_addr[5:0]};
    voice_data <= {2'd2, rom_addr[5:0]};
    beep_data  <= {2'd3, rom_addr[5:0]};
  end

  always @(posedge clk or negedge system_reset) begin
    if (!system_reset) ph <= 3'd0;
    else               ph <= ph + 3'd1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the next sample_valid and check it. exp_sel=0 means a
  // silence sample, which arrives the cycle after the tick with busy low.
  task automatic expect_sample(input string tag, input logic [7:0] exp_data,
                               input logic exp_done, input logic [1:0] exp_sel,
                               input logic [15:0] exp_addr);
    int  n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 64) begin
      @(negedge clk);
      n++;
      if (sample_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    assert (seen === 1'b1) else begin
      failures++;
      $error("FAIL %s_timeout got=no_sample_valid exp=sample_valid", tag);
    end
    if (seen) begin
      $display("txn %s sample=%h done=%b sel=%0d addr=%0d phase=%0d busy=%b",
               tag, sample, clip_done, rom_sel, rom_addr, ph, busy);
      check({tag, "_data"}, 16'(sample), 16'(exp_data));
      check({tag, "_done"}, 16'(clip_done), 16'(exp_done));
      if (exp_sel != 2'd0) begin
        check({tag, "_sel"}, 16'(rom_sel), 16'(exp_sel));
        check({tag, "_addr"}, rom_addr, exp_addr);
        check({tag, "_phase"}, 16'(ph), 16'd2);
      end else begin
        check({tag, "_phase"}, 16'(ph), 16'd0);
        check({tag, "_busy"}, 16'(busy), 16'd0);
      end
    end
  endtask

  task automatic pulse(input logic v, input logic b);
    @(negedge clk);
    voice_req = v;
    beep_req  = b;
    @(negedge clk);
    voice_req = 1'b0;
    beep_req  = 1'b0;
  endtask

  initial begin
    int nvalid;
    system_reset = 1'b0;
    alarm_en     = 1'b0;
    voice_req    = 1'b0;
    beep_req     = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_sample", 16'(sample), 16'h00);
    check("rst_valid",  16'(sample_valid), 16'd0);
    check("rst_done",   16'(clip_done), 16'd0);
    check("rst_busy",   16'(busy), 16'd0);
    check("rst_sel",    16'(rom_sel), 16'd0);
    check("rst_addr",   rom_addr, 16'd0);
    system_reset = 1'b1;

    // 1: reset in the middle of a voice clip
    pulse(1'b1, 1'b0);
    check("t1_busy_pending", 16'(busy), 16'd1);
    expect_sample("t1_v0", 8'h80, 1'b0, 2'd2, 16'd0);
    @(negedge clk);
    #2 system_reset = 1'b0;
    #1;
    check("t1_rst_sample", 16'(sample), 16'h00);
    check("t1_rst_sel",    16'(rom_sel), 16'd0);
    check("t1_rst_busy",   16'(busy), 16'd0);
    check("t1_rst_valid",  16'(sample_valid), 16'd0);
    @(negedge clk);
    system_reset = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) nvalid++;
    end
    check("t1_no_output_after_reset", 16'(nvalid), 16'd0);
    check("t1_idle_busy", 16'(busy), 16'd0);

    // 2: single beep from idle
    pulse(1'b0, 1'b1);
    expect_sample("t2_b0", 8'hC0, 1'b0, 2'd3, 16'd0);
    expect_sample("t2_b1", 8'hC1, 1'b1, 2'd3, 16'd1);
    expect_sample("t2_sil", 8'h00, 1'b0, 2'd0, 16'd0);

    // 3: alarm looping for 10 ticks, then stop and restart
    @(negedge clk);
    alarm_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      expect_sample($sformatf("t3_a%0d", i), 8'(8'h40 + (i % 4)), 1'b0, 2'd1, 16'(i % 4));
    end
    alarm_en = 1'b0;
    expect_sample("t3_sil", 8'h00, 1'b0, 2'd0, 16'd0);
    alarm_en = 1'b1;
    expect_sample("t3_restart", 8'h40, 1'b0, 2'd1, 16'd0);
    alarm_en = 1'b0;
    expect_sample("t3_sil2", 8'h00, 1'b0, 2'd0, 16'd0);

    // 4: voice and beep requested together
    pulse(1'b1, 1'b1);
    expect_sample("t4_v0", 8'h80, 1'b0, 2'd2, 16'd0);
    expect_sample("t4_v1", 8'h81, 1'b0, 2'd2, 16'd1);
    expect_sample("t4_v2", 8'h82, 1'b1, 2'd2, 16'd2);
    expect_sample("t4_b0", 8'hC0, 1'b0, 2'd3, 16'd0);
    expect_sample("t4_b1", 8'hC1, 1'b1, 2'd3, 16'd1);
    expect_sample("t4_sil", 8'h00, 1'b0, 2'd0, 16'd0);

    // 5: alarm preempts voice at addr 1; beep requested during alarm plays after
    pulse(1'b1, 1'b0);
    expect_sample("t5_v0", 8'h80, 1'b0, 2'd2, 16'd0);
    expect_sample("t5_v1", 8'h81, 1'b0, 2'd2, 16'd1);
    alarm_en = 1'b1;
    expect_sample("t5_a0", 8'h40, 1'b0, 2'd1, 16'd0);
    pulse(1'b0, 1'b1);
    expect_sample("t5_a1", 8'h41, 1'b0, 2'd1, 16'd1);
    alarm_en = 1'b0;
    expect_sample("t5_b0", 8'hC0, 1'b0, 2'd3, 16'd0);
    expect_sample("t5_b1", 8'hC1, 1'b1, 2'd3, 16'd1);
    expect_sample("t5_sil", 8'h00, 1'b0, 2'd0, 16'd0);

    // 6: repeated beep request while beep is playing is ignored
    pulse(1'b0, 1'b1);
    expect_sample("t6_b0", 8'hC0, 1'b0, 2'd3, 16'd0);
    pulse(1'b0, 1'b1);
    expect_sample("t6_b1", 8'hC1, 1'b1, 2'd3, 16'd1);
    expect_sample("t6_sil", 8'h00, 1'b0, 2'd0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
